// File: rtl/led_cmd_sched_if.sv
// Key-event inputs and counter-command outputs of the LED command scheduler.
// The master modport drives the keys; the slave modport is the scheduler.
interface led_cmd_sched_if;
    logic       key_flag0;
    logic       key_state0;
    logic       key_flag1;
    logic       key_state1;
    logic       cmd_inc;
    logic       cmd_dec;
    logic       busy;
    logic [1:0] rpt_act;

    modport master (
        output key_flag0, key_state0, key_flag1, key_state1,
        input  cmd_inc, cmd_dec, busy, rpt_act
    );

    modport slave (
        input  key_flag0, key_state0, key_flag1, key_state1,
        output cmd_inc, cmd_dec, busy, rpt_act
    );
endinterface

// File: rtl/led_cmd_sched.sv
// LED command scheduler: turns debounced key presses and auto-repeat ticks into
// spaced, mutually exclusive one-cycle increment/decrement commands.
module led_cmd_sched #(
    parameter int HOLD_CYC   = 25_000_000,
    parameter int REPEAT_CYC = 5_000_000,
    parameter int GAP_CYC    = 4,
    parameter int PEND_MAX   = 3
) (
    input  logic           Clk,
    input  logic           Rst_n,
    led_cmd_sched_if.slave bus
);
    localparam int TMR_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
    localparam int TMR_W   = ($clog2(TMR_MAX) > 0) ? $clog2(TMR_MAX) : 1;
    localparam int GAP_W   = ($clog2(GAP_CYC + 1) > 0) ? $clog2(GAP_CYC + 1) : 1;
    localparam logic [TMR_W-1:0] HOLD_TERM = TMR_W'(HOLD_CYC - 1);
    localparam logic [TMR_W-1:0] RPT_TERM  = TMR_W'(REPEAT_CYC - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(GAP_CYC - 1);
    localparam logic [2:0]       PEND_SAT  = 3'(PEND_MAX);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t                 state_r, state_nxt_s;
    logic                   gnt_r, gnt_nxt_s;
    logic                   rr_r, rr_nxt_s;
    logic [GAP_W-1:0]       gap_r, gap_nxt_s;
    logic [1:0]             key_flag_s, key_state_s, press_s, tick_s, inc_s, dec_s, req_s;
    logic [1:0][2:0]        pend_r, pend_nxt_s;
    logic [1:0][TMR_W-1:0]  tmr_r, tmr_nxt_s;
    logic [1:0]             rpt_r, rpt_nxt_s;
    logic                   cmd_inc_r, cmd_dec_r, busy_r;

    assign key_flag_s  = {bus.key_flag1, bus.key_flag0};
    assign key_state_s = {bus.key_state1, bus.key_state0};
    assign press_s     = key_flag_s & ~key_state_s;
    assign inc_s       = press_s | tick_s;
    assign req_s       = {(pend_r[1] != 3'd0), (pend_r[0] != 3'd0)};

    // Hold/repeat timers: any edge or a released key restarts the hold phase
    always_comb begin
        tmr_nxt_s = tmr_r;
        rpt_nxt_s = rpt_r;
        tick_s    = 2'b00;
        for (int k = 0; k < 2; k++) begin
            if (key_flag_s[k] || key_state_s[k]) begin
                tmr_nxt_s[k] = '0;
                rpt_nxt_s[k] = 1'b0;
            end else if (tmr_r[k] == (rpt_r[k] ? RPT_TERM : HOLD_TERM)) begin
                tick_s[k]    = 1'b1;
                rpt_nxt_s[k] = 1'b1;
                tmr_nxt_s[k] = '0;
            end else begin
                tmr_nxt_s[k] = tmr_r[k] + 1'b1;
            end
        end
    end

    // Scheduler next-state: round-robin grant, one ISSUE cycle, then a gap
    always_comb begin
        state_nxt_s = state_r;
        gnt_nxt_s   = gnt_r;
        rr_nxt_s    = rr_r;
        gap_nxt_s   = gap_r;
        dec_s       = 2'b00;
        case (state_r)
            ST_IDLE: begin
                if (req_s == 2'b11) begin
                    gnt_nxt_s   = ~rr_r;
                    rr_nxt_s    = ~rr_r;
                    state_nxt_s = ST_ISSUE;
                end else if (req_s[0]) begin
                    gnt_nxt_s   = 1'b0;
                    state_nxt_s = ST_ISSUE;
                end else if (req_s[1]) begin
                    gnt_nxt_s   = 1'b1;
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                dec_s[gnt_r] = 1'b1;
                gap_nxt_s    = GAP_LOAD;
                state_nxt_s  = ST_GAP;
            end
            ST_GAP: begin
                if (gap_r == '0) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    gap_nxt_s = gap_r - 1'b1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                gap_nxt_s   = '0;
            end
        endcase
    end

    // Pending counters: saturating increment, decrement on issue, net zero when both
    always_comb begin
        pend_nxt_s = pend_r;
        for (int k = 0; k < 2; k++) begin
            if (inc_s[k] && !dec_s[k]) begin
                pend_nxt_s[k] = (pend_r[k] >= PEND_SAT) ? pend_r[k] : pend_r[k] + 3'd1;
            end else if (dec_s[k] && !inc_s[k] && (pend_r[k] != 3'd0)) begin
                pend_nxt_s[k] = pend_r[k] - 3'd1;
            end else begin
                pend_nxt_s[k] = pend_r[k];
            end
        end
    end

    // Scheduler state register
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_r <= ST_IDLE;
            gnt_r   <= 1'b0;
            rr_r    <= 1'b1;
            gap_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            gnt_r   <= gnt_nxt_s;
            rr_r    <= rr_nxt_s;
            gap_r   <= gap_nxt_s;
        end
    end

    // Per-key pending counters, hold timers and repeat flags
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pend_r <= '0;
            tmr_r  <= '0;
            rpt_r  <= 2'b00;
        end else begin
            pend_r <= pend_nxt_s;
            tmr_r  <= tmr_nxt_s;
            rpt_r  <= rpt_nxt_s;
        end
    end

    // Outputs are registered from next-state so commands align with ISSUE
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cmd_inc_r <= 1'b0;
            cmd_dec_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            cmd_inc_r <= (state_nxt_s == ST_ISSUE) && !gnt_nxt_s;
            cmd_dec_r <= (state_nxt_s == ST_ISSUE) && gnt_nxt_s;
            busy_r    <= (state_nxt_s != ST_IDLE) || (|pend_nxt_s);
        end
    end

    assign bus.cmd_inc = cmd_inc_r;
    assign bus.cmd_dec = cmd_dec_r;
    assign bus.busy    = busy_r;
    assign bus.rpt_act = rpt_r;
endmodule
